// File: rtl/spi_boot_master.sv
// spi_boot_master: streams a word image into an SPI device as (cmd, addr, data) writes,
// stops at a sentinel word or the word limit, then pulses fetch enable.
module spi_boot_master #(
  parameter int                CMD_W      = 8,
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [CMD_W-1:0]  WRITE_CMD  = 8'h02,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h80,
  parameter logic [DATA_W-1:0] END_WORD   = 32'h00000fff,
  parameter int                MAX_WORDS  = 32,
  parameter int                CLK_DIV    = 2,
  parameter int                GAP_CYCLES = 100,
  parameter int                FE_CYCLES  = 10
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic                               quad_i,
  output logic                               word_req_o,
  output logic [$clog2(MAX_WORDS)-1:0]       word_idx_o,
  input  logic [DATA_W-1:0]                  word_i,
  input  logic                               word_valid_i,
  output logic                               spi_sclk_o,
  output logic                               spi_cs_o,
  output logic [3:0]                         spi_sdo_o,
  output logic [1:0]                         spi_mode_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               fetch_enable_o,
  output logic [$clog2(MAX_WORDS+1)-1:0]     words_sent_o
);
  localparam int L    = CMD_W + ADDR_W + DATA_W;
  localparam int IW   = $clog2(MAX_WORDS);
  localparam int CW   = $clog2(MAX_WORDS + 1);
  localparam int TMAX = CLK_DIV > GAP_CYCLES ? CLK_DIV : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(L + 1);
  localparam int FW   = $clog2(FE_CYCLES + 2);

  typedef enum logic [2:0] {IDLE, FETCH, CS_SETUP, SHIFT, CS_HOLD, GAP, DONE} state_t;

  state_t          state_q, state_d;
  logic [L-1:0]    shreg_q, shreg_d;
  logic            quad_q, quad_d;
  logic            last_q, last_d;
  logic            sclk_q, sclk_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   words_q, words_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bits_q, bits_d;
  logic [FW-1:0]   fe_q, fe_d;
  logic [ADDR_W-1:0] addr;
  logic            tick, gap_end, last_period, cs_active;

  assign addr        = BASE_ADDR + (ADDR_W'(idx_q) << 2);
  assign tick        = cnt_q == TW'(CLK_DIV - 1);
  assign gap_end     = cnt_q == TW'(GAP_CYCLES - 1);
  assign last_period = bits_q == (quad_q ? BW'(L / 4 - 1) : BW'(L - 1));
  assign cs_active   = state_q inside {CS_SETUP, SHIFT, CS_HOLD};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    quad_d  = quad_q;
    last_d  = last_q;
    sclk_d  = sclk_q;
    idx_d   = idx_q;
    words_d = words_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    fe_d    = fe_q;
    case (state_q)
      IDLE, DONE: begin
        fe_d = fe_q != '0 ? fe_q - FW'(1) : fe_q;
        if (start_i) begin
          quad_d  = quad_i;
          idx_d   = '0;
          words_d = '0;
          cnt_d   = '0;
          fe_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (word_valid_i) begin
          shreg_d = {WRITE_CMD, addr, word_i};
          last_d  = word_i == END_WORD;
          cnt_d   = '0;
          state_d = CS_SETUP;
        end
      end
      CS_SETUP: begin
        cnt_d   = tick ? '0 : cnt_q + TW'(1);
        bits_d  = '0;
        state_d = tick ? SHIFT : CS_SETUP;
      end
      SHIFT: begin
        cnt_d = tick ? '0 : cnt_q + TW'(1);
        // data advances on the falling edge, one period counted per falling edge
        if (tick) begin
          sclk_d = !sclk_q;
          if (sclk_q) begin
            shreg_d = quad_q ? {shreg_q[L-5:0], 4'b0} : {shreg_q[L-2:0], 1'b0};
            bits_d  = bits_q + BW'(1);
            state_d = last_period ? CS_HOLD : SHIFT;
          end
        end
      end
      CS_HOLD: begin
        cnt_d = tick ? '0 : cnt_q + TW'(1);
        if (tick) begin
          words_d = words_q == CW'(MAX_WORDS) ? words_q : words_q + CW'(1);
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d = gap_end ? '0 : cnt_q + TW'(1);
        if (gap_end) begin
          if (last_q || idx_q == IW'(MAX_WORDS - 1)) begin
            fe_d    = FW'(FE_CYCLES);
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      quad_q  <= 1'b0;
      last_q  <= 1'b0;
      sclk_q  <= 1'b0;
      idx_q   <= '0;
      words_q <= '0;
      cnt_q   <= '0;
      bits_q  <= '0;
      fe_q    <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      quad_q  <= quad_d;
      last_q  <= last_d;
      sclk_q  <= sclk_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      fe_q    <= fe_d;
    end
  end

  assign word_req_o     = state_q == FETCH;
  assign word_idx_o     = idx_q;
  assign spi_sclk_o     = sclk_q;
  assign spi_cs_o       = !cs_active;
  assign spi_sdo_o      = (state_q inside {CS_SETUP, SHIFT}) ?
                          (quad_q ? shreg_q[L-1 -: 4] : {3'b000, shreg_q[L-1]}) : 4'b0000;
  assign busy_o         = !(state_q inside {IDLE, DONE});
  assign spi_mode_o     = (busy_o && quad_q) ? 2'b10 : 2'b00;
  assign done_o         = state_q == DONE;
  assign fetch_enable_o = state_q == DONE && fe_q != '0;
  assign words_sent_o   = words_q;
endmodule

// File: tb/tb_spi_boot_master.sv
// tb_spi_boot_master: directed scenarios against an SPI slave model and a latency-controlled word source.
module tb_spi_boot_master;
  logic        clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, quad_i = 1'b0;
  logic        word_req_o, word_valid_i, spi_sclk_o, spi_cs_o, busy_o, done_o, fetch_enable_o;
  logic [4:0]  word_idx_o;
  logic [31:0] word_i;
  logic [3:0]  spi_sdo_o;
  logic [1:0]  spi_mode_o;
  logic [5:0]  words_sent_o;

  spi_boot_master dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .quad_i(quad_i),
    .word_req_o(word_req_o), .word_idx_o(word_idx_o), .word_i(word_i), .word_valid_i(word_valid_i),
    .spi_sclk_o(spi_sclk_o), .spi_cs_o(spi_cs_o), .spi_sdo_o(spi_sdo_o), .spi_mode_o(spi_mode_o),
    .busy_o(busy_o), .done_o(done_o), .fetch_enable_o(fetch_enable_o), .words_sent_o(words_sent_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [71:0] E0 = {8'h02, 32'h00000080, 32'h00500093};
  localparam logic [71:0] E1 = {8'h02, 32'h00000084, 32'h00000fff};

  int checks = 0, errors = 0;

  logic [31:0] img [32];
  int latency = 0, lat_cnt = 0;
  assign word_valid_i = word_req_o && (lat_cnt >= latency);
  assign word_i       = img[word_idx_o];
  always @(posedge clk_i) lat_cnt <= (word_req_o && !word_valid_i) ? lat_cnt + 1 : 0;

  logic [71:0] cap;
  int          rises;
  logic [71:0] tx_q[$];
  int          rise_q[$], cslow_q[$], gap_q[$], fe_q[$], req_q[$];
  int          cs_run = 0, gap_run = 0, fe_run = 0, req_run = 0, mode_err = 0, lane_err = 0;
  bit          seen_tx = 0, fe_at_entry = 0, done_prev = 0, mon_en = 0;
  logic [1:0]  exp_mode = 2'b00;

  always @(negedge spi_cs_o) begin cap = '0; rises = 0; end
  always @(posedge spi_sclk_o) if (!spi_cs_o) begin
    if (exp_mode == 2'b10) cap = {cap[67:0], spi_sdo_o};
    else begin
      cap = {cap[70:0], spi_sdo_o[0]};
      if (spi_sdo_o[3:1] != 3'b000) lane_err++;
    end
    rises++;
  end
  always @(posedge spi_cs_o) begin tx_q.push_back(cap); rise_q.push_back(rises); end

  always @(negedge clk_i) if (mon_en) begin
    if (!spi_cs_o) begin cs_run++; seen_tx = 1; end
    else if (cs_run != 0) begin cslow_q.push_back(cs_run); cs_run = 0; end
    if (!busy_o) begin seen_tx = 0; gap_run = 0; end
    else if (spi_cs_o && !word_req_o && seen_tx) gap_run++;
    else if (word_req_o && gap_run != 0) begin gap_q.push_back(gap_run); gap_run = 0; end
    if (fetch_enable_o) fe_run++;
    else if (fe_run != 0) begin fe_q.push_back(fe_run); fe_run = 0; end
    if (done_o && !done_prev) fe_at_entry = fetch_enable_o;
    done_prev = done_o;
    if (word_req_o) req_run++;
    if (word_req_o && word_valid_i) begin req_q.push_back(req_run); req_run = 0; end
    if (busy_o && spi_mode_o !== exp_mode) mode_err++;
    if (!busy_o && spi_mode_o !== 2'b00) mode_err++;
  end

  task automatic clear_mon();
    tx_q.delete(); rise_q.delete(); cslow_q.delete(); gap_q.delete(); fe_q.delete(); req_q.delete();
    req_run = 0; mode_err = 0; lane_err = 0; fe_at_entry = 0;
  endtask

  task automatic set_img2();
    for (int i = 0; i < 32; i++) img[i] = 32'h0;
    img[0] = 32'h00500093; img[1] = 32'h00000fff;
  endtask

  task automatic set_img_seq();
    for (int i = 0; i < 32; i++) img[i] = 32'(i + 1);
  endtask

  task automatic start_load(input logic q);
    @(negedge clk_i);
    clear_mon();
    exp_mode = q ? 2'b10 : 2'b00;
    start_i = 1'b1; quad_i = q;
    @(negedge clk_i);
    start_i = 1'b0; quad_i = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_i);
      if (done_o) begin ok = 1; break; end
    end
  endtask

  task automatic run_load(input logic q, input int lat, output bit ok);
    latency = lat;
    start_load(q);
    wait_done(ok);
    repeat (13) @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    mon_en = 1;
    checks++; if (spi_cs_o !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b expected 1", spi_cs_o); end
    checks++; if (spi_sclk_o !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", spi_sclk_o); end
    checks++; if (spi_sdo_o !== 4'h0) begin errors++; $display("FAIL reset_sdo: got %h expected 0", spi_sdo_o); end
    checks++; if (spi_mode_o !== 2'b00) begin errors++; $display("FAIL reset_mode: got %b expected 00", spi_mode_o); end
    checks++; if ({word_req_o, busy_o, done_o, fetch_enable_o} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {word_req_o, busy_o, done_o, fetch_enable_o}); end
    checks++; if (words_sent_o !== 6'd0 || word_idx_o !== 5'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", words_sent_o, word_idx_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_single();
    bit ok;
    set_img2();
    run_load(1'b0, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got no done expected done"); end
    checks++; if (tx_q.size() != 2) begin errors++; $display("FAIL single_tx_count: got %0d expected 2", tx_q.size()); end
    checks++; if (tx_q[0] !== E0) begin errors++; $display("FAIL single_tx0: got %h expected %h", tx_q[0], E0); end
    checks++; if (tx_q[1] !== E1) begin errors++; $display("FAIL single_tx1: got %h expected %h", tx_q[1], E1); end
    checks++; if (rise_q[0] != 72 || rise_q[1] != 72) begin errors++; $display("FAIL single_rises: got %0d,%0d expected 72,72", rise_q[0], rise_q[1]); end
    checks++; if (cslow_q[0] != 292) begin errors++; $display("FAIL single_cs_low: got %0d expected 292", cslow_q[0]); end
    checks++; if (gap_q.size() != 1 || gap_q[0] != 100) begin errors++; $display("FAIL single_gap: got %0d entries, %0d expected 1, 100", gap_q.size(), gap_q[0]); end
    checks++; if (words_sent_o !== 6'd2) begin errors++; $display("FAIL single_words: got %0d expected 2", words_sent_o); end
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL single_done_busy: got %b%b expected 10", done_o, busy_o); end
    checks++; if (fe_q.size() != 1 || fe_q[0] != 10) begin errors++; $display("FAIL single_fe_width: got %0d pulses, %0d expected 1, 10", fe_q.size(), fe_q[0]); end
    checks++; if (fe_at_entry !== 1'b1) begin errors++; $display("FAIL single_fe_entry: got %b expected 1", fe_at_entry); end
    checks++; if (mode_err != 0 || lane_err != 0) begin errors++; $display("FAIL single_mode_lanes: got %0d/%0d expected 0/0", mode_err, lane_err); end
  endtask

  task automatic test_quad();
    bit ok;
    set_img2();
    run_load(1'b1, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL quad_timeout: got no done expected done"); end
    checks++; if (tx_q.size() != 2) begin errors++; $display("FAIL quad_tx_count: got %0d expected 2", tx_q.size()); end
    checks++; if (tx_q[0][71:64] !== 8'h02) begin errors++; $display("FAIL quad_nibbles: got %h expected 02", tx_q[0][71:64]); end
    checks++; if (tx_q[0] !== E0) begin errors++; $display("FAIL quad_tx0: got %h expected %h", tx_q[0], E0); end
    checks++; if (tx_q[1] !== E1) begin errors++; $display("FAIL quad_tx1: got %h expected %h", tx_q[1], E1); end
    checks++; if (rise_q[0] != 18 || rise_q[1] != 18) begin errors++; $display("FAIL quad_rises: got %0d,%0d expected 18,18", rise_q[0], rise_q[1]); end
    checks++; if (cslow_q[0] != 76) begin errors++; $display("FAIL quad_cs_low: got %0d expected 76", cslow_q[0]); end
    checks++; if (mode_err != 0) begin errors++; $display("FAIL quad_mode: got %0d bad cycles expected 0", mode_err); end
    checks++; if (spi_mode_o !== 2'b00) begin errors++; $display("FAIL quad_mode_idle: got %b expected 00", spi_mode_o); end
    checks++; if (words_sent_o !== 6'd2 || fe_q.size() != 1 || fe_q[0] != 10) begin errors++; $display("FAIL quad_end: got words %0d fe %0d expected 2, 10", words_sent_o, fe_q[0]); end
  endtask

  task automatic test_no_sentinel();
    bit ok;
    set_img_seq();
    run_load(1'b0, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL limit_timeout: got no done expected done"); end
    checks++; if (tx_q.size() != 32) begin errors++; $display("FAIL limit_tx_count: got %0d expected 32", tx_q.size()); end
    checks++; if (tx_q[31] !== {8'h02, 32'h000000fc, 32'd32}) begin errors++; $display("FAIL limit_last_tx: got %h expected 02000000fc00000020", tx_q[31]); end
    checks++; if (tx_q[17] !== {8'h02, 32'h000000c4, 32'd18}) begin errors++; $display("FAIL limit_mid_tx: got %h expected 02000000c400000012", tx_q[17]); end
    checks++; if (words_sent_o !== 6'd32) begin errors++; $display("FAIL limit_words: got %0d expected 32", words_sent_o); end
    checks++; if (word_idx_o !== 5'd31) begin errors++; $display("FAIL limit_idx: got %0d expected 31", word_idx_o); end
  endtask

  task automatic test_latency();
    bit ok;
    int lats [3] = '{0, 1, 7};
    set_img2();
    foreach (lats[k]) begin
      run_load(1'b0, lats[k], ok);
      checks++; if (!ok) begin errors++; $display("FAIL lat%0d_timeout: got no done expected done", lats[k]); end
      checks++; if (req_q.size() != 2 || req_q[0] != lats[k] + 1 || req_q[1] != lats[k] + 1) begin errors++; $display("FAIL lat%0d_req_hold: got %0d,%0d expected %0d", lats[k], req_q[0], req_q[1], lats[k] + 1); end
      checks++; if (tx_q.size() != 2 || tx_q[0] !== E0 || tx_q[1] !== E1) begin errors++; $display("FAIL lat%0d_tx: got %h %h expected %h %h", lats[k], tx_q[0], tx_q[1], E0, E1); end
      checks++; if (cslow_q[0] != 292 || cslow_q[1] != 292 || gap_q[0] != 100) begin errors++; $display("FAIL lat%0d_timing: got %0d,%0d,%0d expected 292,292,100", lats[k], cslow_q[0], cslow_q[1], gap_q[0]); end
    end
    latency = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    set_img_seq();
    start_load(1'b0);
    while (tx_q.size() < 3 && n < 5000) begin @(negedge clk_i); n++; end
    while (spi_cs_o && n < 5000) begin @(negedge clk_i); n++; end
    checks++; if (n >= 5000) begin errors++; $display("FAIL rstmid_reach: got timeout expected word 3 shifting"); end
    repeat (40) @(negedge clk_i);
    checks++; if (words_sent_o !== 6'd3 || spi_cs_o !== 1'b0) begin errors++; $display("FAIL rstmid_pre: got words %0d cs %b expected 3, 0", words_sent_o, spi_cs_o); end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++; if (spi_cs_o !== 1'b1 || spi_sclk_o !== 1'b0 || spi_sdo_o !== 4'h0) begin errors++; $display("FAIL rstmid_spi: got cs %b sclk %b sdo %h expected 1 0 0", spi_cs_o, spi_sclk_o, spi_sdo_o); end
    checks++; if (busy_o !== 1'b0 || words_sent_o !== 6'd0 || word_idx_o !== 5'd0) begin errors++; $display("FAIL rstmid_state: got busy %b words %0d idx %0d expected 0 0 0", busy_o, words_sent_o, word_idx_o); end
    rst_i = 1'b0;
    set_img2();
    repeat (2) @(negedge clk_i);
    run_load(1'b0, 0, ok);
    checks++; if (!ok || tx_q.size() != 2 || tx_q[0] !== E0) begin errors++; $display("FAIL rstmid_reload: got ok %b n %0d tx0 %h expected 1 2 %h", ok, tx_q.size(), tx_q[0], E0); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n = 0;
    set_img2();
    start_load(1'b0);
    while (spi_cs_o && n < 1000) begin @(negedge clk_i); n++; end
    repeat (20) @(negedge clk_i);
    start_i = 1'b1; quad_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; quad_i = 1'b0;
    checks++; if (busy_o !== 1'b1 || spi_cs_o !== 1'b0) begin errors++; $display("FAIL ignore_shift: got busy %b cs %b expected 1 0", busy_o, spi_cs_o); end
    wait_done(ok);
    checks++; if (!ok || tx_q.size() != 2 || tx_q[1] !== E1 || rise_q[0] != 72) begin errors++; $display("FAIL ignore_result: got n %0d tx1 %h rises %0d expected 2 %h 72", tx_q.size(), tx_q[1], rise_q[0], E1); end
    checks++; if (mode_err != 0) begin errors++; $display("FAIL ignore_mode: got %0d bad cycles expected 0", mode_err); end
    repeat (3) @(negedge clk_i);
    checks++; if (fetch_enable_o !== 1'b1) begin errors++; $display("FAIL restart_pre_fe: got %b expected 1", fetch_enable_o); end
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    checks++; if (fetch_enable_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL restart_fe_drop: got fe %b done %b expected 0 0", fetch_enable_o, done_o); end
    checks++; if (busy_o !== 1'b1 || word_idx_o !== 5'd0 || words_sent_o !== 6'd0) begin errors++; $display("FAIL restart_state: got busy %b idx %0d words %0d expected 1 0 0", busy_o, word_idx_o, words_sent_o); end
    @(negedge clk_i);
    clear_mon();
    wait_done(ok);
    repeat (13) @(negedge clk_i);
    checks++; if (!ok || tx_q.size() != 2 || tx_q[0] !== E0) begin errors++; $display("FAIL restart_reload: got ok %b n %0d tx0 %h expected 1 2 %h", ok, tx_q.size(), tx_q[0], E0); end
    checks++; if (words_sent_o !== 6'd2 || fe_q.size() != 1 || fe_q[0] != 10) begin errors++; $display("FAIL restart_end: got words %0d fe %0d expected 2, 10", words_sent_o, fe_q[0]); end
  endtask

  initial begin
    set_img2();
    test_reset();
    test_single();
    test_quad();
    test_no_sentinel();
    test_latency();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_boot_master.md
Name: spi_boot_master

Overview:
Synthesizable SPI-master boot loader. It streams a program image from a word source into the core's SPI device as a sequence of write transactions (cmd, addr, data), stops at a sentinel word, then pulses fetch enable. It is the parametrised, in-silicon successor to the bench-side SPI load loop. It adds single/quad lane mode, a programmable clock divider, a word-count limit and a completion handshake.

Parameters:
CMD_W, 8, command field width in bits
ADDR_W, 32, address field width
DATA_W, 32, data word width
WRITE_CMD, 8'h02, command byte sent on every transaction
BASE_ADDR, 32'h80, address of word 0; word n goes to BASE_ADDR + 4*n, modulo 2^ADDR_W
END_WORD, 32'h00000fff, sentinel value; it is transmitted, then loading stops
MAX_WORDS, 32, hard limit on words per load (>=2)
CLK_DIV, 2, clk_i cycles per sclk half-period (>=1)
GAP_CYCLES, 100, clk_i cycles with CS high between transactions (>=1)
FE_CYCLES, 10, width of the fetch_enable_o pulse in clk_i cycles

Ports:
clk_i  in  1  single clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  begin load; sampled only in IDLE or DONE
quad_i  in  1  0 = single lane, 1 = quad lane; latched on accepted start_i
word_req_o  out  1  request for the image word at word_idx_o
word_idx_o  out  $clog2(MAX_WORDS)  index of the requested word
word_i  in  DATA_W  image word
word_valid_i  in  1  word_i is valid; completes the request
spi_sclk_o  out  1  SPI clock, idles low (mode 0)
spi_cs_o  out  1  chip select, active-low
spi_sdo_o  out  4  serial data; lane 3 carries the MSB in quad mode, lane 0 in single mode
spi_mode_o  out  2  2'b00 single, 2'b10 quad
busy_o  out  1  high from start accept until DONE
done_o  out  1  load complete; held until the next start_i or reset
fetch_enable_o  out  1  FE_CYCLES-wide pulse on entering DONE
words_sent_o  out  $clog2(MAX_WORDS+1)  count of completed transactions

Behaviour:
- Reset (synchronous, rst_i=1 at a clk_i edge) takes effect in every state, including mid-transaction.
  - FSM goes to IDLE; word_idx_o, words_sent_o and all counters clear.
  - Reset output values: spi_cs_o=1, spi_sclk_o=0, spi_sdo_o=0, spi_mode_o=0; word_req_o, busy_o, done_o and fetch_enable_o are 0.
- FSM states: IDLE, FETCH, CS_SETUP, SHIFT, CS_HOLD, GAP, DONE.
- IDLE/DONE, start_i=1: latch quad_i, clear idx/count/done_o, set busy_o, go to FETCH next cycle. start_i in any other state is ignored.
- FETCH: word_req_o=1 until word_valid_i. Latency is unbounded, and word_valid_i in the same cycle as the request is allowed.
  - On word_valid_i, load shift register = {WRITE_CMD, BASE_ADDR+4*idx, word_i}, MSB first (L = CMD_W+ADDR_W+DATA_W bits).
  - Drop word_req_o, go to CS_SETUP.
- CS_SETUP: spi_cs_o=0, sclk low, first bit/nibble on sdo, for CLK_DIV cycles, then SHIFT.
- SHIFT:
  - sclk toggles every CLK_DIV cycles. The slave samples on the rising edge; the master advances data on the falling edge.
  - Single mode: L sclk periods, 1 bit on sdo[0], sdo[3:1]=0.
  - Quad mode: L/4 periods, 4 bits per period on sdo[3:0]. Require L%4==0.
  - After the final falling edge, go to CS_HOLD.
- CS_HOLD: sclk low, CS low for CLK_DIV cycles, then CS high, increment words_sent_o, go to GAP.
- GAP: CS high for GAP_CYCLES cycles. Then:
  - if the captured word == END_WORD or idx == MAX_WORDS-1, go to DONE;
  - else idx++ and go to FETCH.
- DONE:
  - busy_o=0, done_o=1.
  - fetch_enable_o=1 for exactly FE_CYCLES cycles starting the cycle DONE is entered.
  - SPI lines idle.
  - A start_i while the pulse is active aborts the pulse and restarts the load.
- spi_mode_o reflects the latched mode while busy_o=1; it is 0 otherwise.
- Address arithmetic wraps at ADDR_W. words_sent_o saturates at MAX_WORDS.
- Sentinel at index 0: exactly one transaction, then DONE.

Test Plan:
- Single mode, defaults, image {0x00500093, 0x00000fff}, zero-latency source.
  - Two transactions: cmd 0x02 at addr 0x80 and 0x84, MSB-first on sdo[0], 72 sclk rising edges each.
  - CS high for 100 cycles between the two transactions.
  - Ends with words_sent_o=2, done_o=1, fetch_enable_o high exactly 10 cycles.
- Quad mode, same image.
  - 18 sclk periods per transaction; first nibble 0x0, second 0x2; spi_mode_o=2'b10 while busy.
  - Slave-model decode matches addr/data.
- No sentinel in 32 words.
  - Stops after 32 transactions, last addr 0x80+4*31=0xFC, words_sent_o=32.
- Source latency 0, 1 and 7 cycles on word_valid_i.
  - word_req_o held until valid; SPI waveform identical apart from start time.
- rst_i asserted mid-SHIFT of word 3.
  - Next cycle: spi_cs_o=1, sclk=0, busy_o=0, words_sent_o=0.
  - A subsequent start_i reloads from addr 0x80.
- start_i pulsed during SHIFT: ignored. start_i pulsed in DONE while fetch_enable_o=1: the pulse drops next cycle and a new load begins at idx 0.
